// File: rtl/mux_scan_capture_pkg.sv
// mux_scan_pkg: shared state type and sizing for the 16:1 mux scan capture block
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        OUT
    } state_t;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 4;

endpackage

// File: rtl/mux_scan_capture_if.sv
// mux_scan_capture_if: scan request, mux select/data and result handshake (SCAN_PARITY_EN adds parity_o)
interface mux_scan_capture_if;
    import mux_scan_pkg::*;

    logic              start_i;
    logic [SEL_W-1:0]  sel_o;
    logic              mux_y_i;
    logic              busy_o;
    logic [NUM_CH-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
`ifdef SCAN_PARITY_EN
    logic              parity_o;

    modport master (input start_i, mux_y_i, ready_i, output sel_o, busy_o, data_o, valid_o, parity_o);
    modport slave  (output start_i, mux_y_i, ready_i, input sel_o, busy_o, data_o, valid_o, parity_o);
`else
    modport master (input start_i, mux_y_i, ready_i, output sel_o, busy_o, data_o, valid_o);
    modport slave  (output start_i, mux_y_i, ready_i, input sel_o, busy_o, data_o, valid_o);
`endif

endinterface

// File: rtl/mux_scan_settle_timer.sv
// mux_scan_settle_timer: counts the settle cycles between a select change and the sample
module mux_scan_settle_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES);

    logic [CNT_W-1:0] cnt;

    // reload on every select change, then count down while settling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= load ? LOAD_VAL : (count && cnt != '0) ? cnt - CNT_W'(1) : cnt;
    end

    // the last settle cycle is the one seen with one count remaining
    assign done = cnt <= CNT_W'(1);

endmodule

// File: rtl/mux_scan_capture.sv
// mux_scan_capture: steps a 16:1 mux select, samples y per channel and hands out the word (SCAN_PARITY_EN adds parity_o)
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input logic                clk,
    input logic                rst_n,
    mux_scan_capture_if.master bus
);

    localparam state_t ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel, sel_nxt;
    logic [NUM_CH-1:0] shadow, shadow_nxt, data;
    logic              load, count, done, capture;
`ifdef SCAN_PARITY_EN
    logic              parity;
`endif

    mux_scan_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .count (count),
        .done  (done)
    );

    // next state, select and shadow word; the last bit goes straight into the output word
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        shadow_nxt = shadow;
        load       = 1'b0;
        count      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: if (bus.start_i) begin
                state_nxt = ENTRY;
                sel_nxt   = '0;
                load      = 1'b1;
            end
            SETTLE: begin
                count     = 1'b1;
                state_nxt = done ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                shadow_nxt[sel] = bus.mux_y_i;
                if (sel == SEL_W'(NUM_CH - 1)) begin
                    state_nxt = OUT;
                    capture   = 1'b1;
                end else begin
                    state_nxt = ENTRY;
                    sel_nxt   = sel + SEL_W'(1);
                    load      = 1'b1;
                end
            end
            OUT: if (bus.ready_i) begin
                state_nxt = bus.start_i ? ENTRY : IDLE;
                sel_nxt   = '0;
                load      = bus.start_i;
            end
        endcase
    end

    // state and datapath registers; reset drops any partial or pending word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            shadow <= '0;
            data   <= '0;
`ifdef SCAN_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            shadow <= shadow_nxt;
            if (capture) begin
                data   <= shadow_nxt;
`ifdef SCAN_PARITY_EN
                parity <= ^shadow_nxt;
`endif
            end
        end
    end

    assign bus.sel_o   = sel;
    assign bus.data_o  = data;
    assign bus.valid_o = state == OUT;
    assign bus.busy_o  = state != IDLE;
`ifdef SCAN_PARITY_EN
    assign bus.parity_o = parity;
`endif

endmodule

// File: tb/tb_mux_scan_capture.sv
// tb_mux_scan_capture: two scanners (settle 1 and settle 0) each driving a behavioural 16:1 mux
module tb_mux_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start = '0;
    logic [1:0]  ready = '0;
    logic [15:0] dd [2];
    logic [1:0]  valid, busy;
    logic [15:0] data [2];
    logic [3:0]  sel [2];
    logic [15:0] hist [0:100];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mux_scan_capture_if bus0 ();
    mux_scan_capture_if bus1 ();

    mux_scan_capture #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mux_scan_capture #(.SETTLE_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.start_i = start[0];
    assign bus1.start_i = start[1];
    assign bus0.ready_i = ready[0];
    assign bus1.ready_i = ready[1];
    assign bus0.mux_y_i = dd[0][bus0.sel_o];
    assign bus1.mux_y_i = dd[1][bus1.sel_o];
    assign valid = {bus1.valid_o, bus0.valid_o};
    assign busy  = {bus1.busy_o, bus0.busy_o};
    assign data[0] = bus0.data_o;
    assign data[1] = bus1.data_o;
    assign sel[0]  = bus0.sel_o;
    assign sel[1]  = bus1.sel_o;
`ifdef SCAN_PARITY_EN
    logic [1:0] par;
    assign par = {bus1.parity_o, bus0.parity_o};
`endif

    typedef struct {
        int          u;
        logic [15:0] d;
        int          hold;
        bit          pulse;
        logic [15:0] exp_d;
        int          exp_lat;
        bit          exp_par;
    } vec_t;

    vec_t tbl [6];

    function automatic int settle_of(input int u);
        return u == 0 ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // waits (bounded) for valid_o; with rnd the mux data changes every cycle and is logged per edge
    task automatic wait_valid(input int u, input bit rnd, output int lat);
        lat = 0;
        while (!valid[u] && lat < 99) begin
            if (rnd) dd[u] = 16'($urandom);
            hist[lat + 1] = dd[u];
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // one full scan from a start pulse through an optional ready hold to the transfer
    task automatic run_scan(input int u, input logic [15:0] dv, input bit rnd, input int hold,
                            input bit pulse, input logic [15:0] exp_fixed, input int exp_lat,
                            input bit exp_par);
        int          lat;
        logic [15:0] exp, h, held;
        dd[u] = dv;
        start[u] = 1'b1;
        ready[u] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start[u] = 1'b0;
        chk("accept_busy", busy[u], 1);
        wait_valid(u, rnd, lat);
        for (int n = 0; n < 16; n++) begin
            h = hist[(n + 1) * (settle_of(u) + 1)];
            exp[n] = h[n];
        end
        if (!rnd) exp = exp_fixed;
        chk("latency", lat, exp_lat);
        chk("valid_up", valid[u], 1);
        chk("data", data[u], exp);
`ifdef SCAN_PARITY_EN
        chk("parity", par[u], rnd ? ^exp : exp_par);
`endif
        held = data[u];
        for (int i = 0; i < hold; i++) begin
            if (pulse) start[u] = i[0];
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", valid[u], 1);
            chk("hold_data", data[u], held);
        end
        start[u] = 1'b0;
        ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready[u] = 1'b0;
        chk("xfer_valid", valid[u], 0);
        chk("xfer_busy", busy[u], 0);
        chk("retain_data", data[u], exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, seen;
        tbl = '{
            '{0, 16'hA5C3, 0,  1'b0, 16'hA5C3, 32, 1'b0},
            '{0, 16'hFFFF, 10, 1'b1, 16'hFFFF, 32, 1'b0},
            '{1, 16'h0001, 0,  1'b0, 16'h0001, 16, 1'b1},
            '{0, 16'h0007, 2,  1'b0, 16'h0007, 32, 1'b1},
            '{1, 16'h0003, 1,  1'b0, 16'h0003, 16, 1'b0},
            '{1, 16'h00FF, 3,  1'b1, 16'h00FF, 16, 1'b0}
        };
        dd[0] = '0;
        dd[1] = '0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_sel", sel[u], 0);
            chk("rst_busy", busy[u], 0);
            chk("rst_valid", valid[u], 0);
            chk("rst_data", data[u], 0);
        end
        rst_n = 1'b1;
        foreach (tbl[i])
            run_scan(tbl[i].u, tbl[i].d, 1'b0, tbl[i].hold, tbl[i].pulse,
                     tbl[i].exp_d, tbl[i].exp_lat, tbl[i].exp_par);

        dd[1] = 16'h0001;
        start[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[1] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("sel_step", sel[1], k);
            @(posedge clk);
            @(negedge clk);
        end
        chk("step_valid", valid[1], 1);
        chk("step_data", data[1], 16'h0001);
        ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready[1] = 1'b0;

        dd[0] = 16'h1234;
        start[0] = 1'b1;
        ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_valid(0, 1'b0, lat);
        chk("b2b_lat1", lat, 32);
        chk("b2b_data1", data[0], 16'h1234);
        dd[0] = 16'h8000;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_gap_valid", valid[0], 0);
        chk("b2b_gap_busy", busy[0], 1);
        wait_valid(0, 1'b0, lat);
        chk("b2b_lat2", lat, 32);
        chk("b2b_data2", data[0], 16'h8000);
        start[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ready[0] = 1'b0;
        chk("b2b_end_busy", busy[0], 0);

        dd[0] = 16'h00FF;
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (sel[0] != 4'd7 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("reach_sel7", sel[0], 7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", sel[0], 0);
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_valid", valid[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (valid[0]) seen++;
        end
        chk("no_valid_after_rst", seen, 0);
        run_scan(0, 16'h00FF, 1'b0, 0, 1'b0, 16'h00FF, 32, 1'b0);

        for (int i = 0; i < 20; i++)
            run_scan(i % 2, 16'($urandom), 1'b1, $urandom_range(0, 3), 1'b1,
                     16'h0000, 16 * (settle_of(i % 2) + 1), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_capture.md
MUX_SCAN_CAPTURE -- requirements
Module: mux_scan_capture

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1: idle cycles between a select change and the sample of mux_y_i (legal range 0..15).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port start_i  input  1  scan request; accepted only as defined in REQ-011 and REQ-016.
REQ-005 The block SHALL have port sel_o  output  4  select to the 16:1 mux `s` input.
REQ-006 The block SHALL have port mux_y_i  input  1  16:1 mux `y` output.
REQ-007 The block SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-008 The block SHALL have port data_o  output  16  captured word; bit n = mux_y_i sampled while sel_o==n.
REQ-009 The block SHALL have port valid_o / ready_i  output / input  1 each  result handshake; transfer occurs when both are high on a rising edge.

Function
REQ-010 The FSM SHALL have states IDLE, SETTLE, SAMPLE and OUT.
REQ-011 IDLE with start_i=1 SHALL load sel_o=0 and go to SETTLE, or go to SAMPLE if SETTLE_CYCLES==0.
REQ-012 SETTLE SHALL count SETTLE_CYCLES cycles with sel_o stable, then go to SAMPLE.
REQ-013 SAMPLE SHALL write mux_y_i into shadow bit sel_o; if sel_o==15 go to OUT, else increment sel_o and go to SETTLE (or stay in SAMPLE if SETTLE_CYCLES==0).
REQ-014 On entry to OUT the block SHALL copy shadow to data_o and assert valid_o; data_o is stable while valid_o is high.
REQ-015 OUT SHALL hold valid_o until ready_i=1, then deassert valid_o; with start_i=0 it returns to IDLE with sel_o=0.
REQ-016 OUT with ready_i=1 and start_i=1 in the same cycle SHALL complete the transfer and start a new scan directly (as REQ-011), with no idle cycle.
REQ-017 start_i in SETTLE or SAMPLE SHALL be ignored and SHALL NOT restart or extend the scan.
REQ-018 Scan latency SHALL be 16*(SETTLE_CYCLES+1) cycles from the start acceptance edge to valid_o high (32 cycles at default).
REQ-019 sel_o SHALL never exceed 15 and SHALL NOT wrap inside a scan.
REQ-020 data_o SHALL retain its last value after a transfer until the next entry to OUT.

Reset
REQ-021 While rst_n=0, the block SHALL set state=IDLE, sel_o=0, data_o=0, shadow=0, settle counter=0, valid_o=0 and busy_o=0 asynchronously.
REQ-022 Reset mid-scan or in OUT SHALL discard the partial or pending word; no valid_o after release until a new full scan.
REQ-023 The first start_i SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-024 With macro SCAN_PARITY_EN defined, the block SHALL add output parity_o (1 bit) = XOR of the 16 captured bits, registered with data_o, reset value 0.
REQ-025 Without SCAN_PARITY_EN, parity_o and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package mux_scan_pkg SHALL hold the state enum type, NUM_CH=16 and SEL_W=4.
REQ-027 The settle counter SHALL be sub-module mux_scan_settle_timer (load, count, done), instantiated once.

Verification
REQ-028 The bench SHALL pair the block with the 16:1 mux. Driving d=16'hA5C3, start pulse and ready_i=1 SHALL give data_o=16'hA5C3 with valid_o rising exactly 32 cycles after acceptance.
REQ-029 With SETTLE_CYCLES=0 and d=16'h0001, the bench SHALL see data_o=16'h0001, 16-cycle latency, and sel_o stepping 0..15 one per cycle.
REQ-030 With d=16'hFFFF and ready_i=0 for 10 cycles, the bench SHALL see valid_o and data_o=16'hFFFF held; start_i pulses during the hold are ignored; the transfer occurs on the first ready_i=1.
REQ-031 With start_i=1 held high, ready_i=1 and d=16'h1234 then 16'h8000, the bench SHALL see back-to-back words 16'h1234 and 16'h8000 with no IDLE cycle between scans.
REQ-032 Asserting rst_n=0 at sel_o==7 SHALL give immediate sel_o=0, busy_o=0 and valid_o=0, with no valid_o until a new start; a rescan of d=16'h00FF SHALL yield 16'h00FF.
REQ-033 With SCAN_PARITY_EN defined, d=16'h0007 SHALL give parity_o=1 and d=16'h0003 SHALL give parity_o=0, each aligned with valid_o.
